// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, selector encodings and the decoded bundle type shared by the decode stage
package decode_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;
   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] MISC_MEM  = 7'b0001111;
   localparam logic [6:0] SYSTEM    = 7'b1110011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_32     = 7'b0111011;

   localparam logic SRC1_REG = 1'b0;
   localparam logic SRC1_PC  = 1'b1;
   localparam logic SRC2_REG = 1'b0;
   localparam logic SRC2_IMM = 1'b1;
   localparam logic WD3_ALU  = 1'b0;
   localparam logic WD3_MEM  = 1'b1;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // imm is kept at the widest XLEN; the stage truncates to its own XLEN
   typedef struct packed {
      logic [63:0] imm;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [4:0]  wa3;
      logic [2:0]  funct3;
      logic [2:0]  rwmm;
      logic [6:0]  funct7;
      logic        src1_selector;
      logic        src2_selector;
      logic        wd3_selector;
      logic        we3;
      logic        wem;
      logic        is_branch_op;
      logic        is_word_op;
      logic        is_muldiv;
      logic        illegal;
   } decoded_t;

   function automatic logic is_shift(input logic [2:0] f3);
      return f3 == 3'b001 || f3 == 3'b101;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I/RV64I instruction decoder; DECODE_MULDIV_EN adds M-extension decode
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] instr,
   output decoded_t    dec
);

   localparam logic RV64 = (XLEN == 64);
`ifdef DECODE_MULDIV_EN
   localparam logic MD = 1'b1;
`else
   localparam logic MD = 1'b0;
`endif

   logic [6:0]  opc, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        bad, word_opc;
   decoded_t    d;

   assign opc = instr[6:0];
   assign rd  = instr[11:7];
   assign f3  = instr[14:12];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign f7  = instr[31:25];
   assign word_opc = opc == OP_IMM_32 || opc == OP_32;

   assign imm_i = {{52{instr[31]}}, instr[31:20]};
   assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // map opcode to bundle fields, then squash side effects of illegal encodings
   always_comb begin
      d = '0;
      bad = 1'b0;
      case (opc)
         OP_IMM, OP_IMM_32: begin
            d.ra1 = rs1;
            d.wa3 = rd;
            d.funct3 = f3;
            d.imm = imm_i;
            d.src2_selector = SRC2_IMM;
            d.we3 = 1'b1;
            d.funct7 = is_shift(f3) ? {instr[31:26], 1'b0} : F7_BASE;
            d.is_word_op = RV64 && word_opc;
            bad = !RV64 && (word_opc || (is_shift(f3) && instr[25]));
         end
         LUI, AUIPC: begin
            d.wa3 = rd;
            d.imm = imm_u;
            d.src1_selector = opc == AUIPC ? SRC1_PC : SRC1_REG;
            d.src2_selector = SRC2_IMM;
            d.we3 = 1'b1;
         end
         OP, OP_32: begin
            d.ra1 = rs1;
            d.ra2 = rs2;
            d.wa3 = rd;
            d.funct3 = f3;
            d.funct7 = f7;
            d.we3 = 1'b1;
            d.is_word_op = RV64 && word_opc;
            d.is_muldiv = MD && f7 == F7_MULDIV;
            bad = (!RV64 && word_opc) || !(f7 == F7_BASE || f7 == F7_ALT || (MD && f7 == F7_MULDIV));
         end
         JAL: begin
            d.wa3 = rd;
            d.imm = imm_j;
            d.src1_selector = SRC1_PC;
            d.src2_selector = SRC2_IMM;
            d.we3 = 1'b1;
            d.is_branch_op = 1'b1;
         end
         JALR: begin
            d.ra1 = rs1;
            d.wa3 = rd;
            d.funct3 = f3;
            d.imm = imm_i;
            d.src2_selector = SRC2_IMM;
            d.we3 = 1'b1;
            d.is_branch_op = 1'b1;
         end
         BRANCH: begin
            d.ra1 = rs1;
            d.ra2 = rs2;
            d.funct3 = f3;
            d.imm = imm_b;
            d.src1_selector = SRC1_PC;
            d.src2_selector = SRC2_IMM;
            d.is_branch_op = 1'b1;
         end
         LOAD: begin
            d.ra1 = rs1;
            d.wa3 = rd;
            d.imm = imm_i;
            d.src2_selector = SRC2_IMM;
            d.wd3_selector = WD3_MEM;
            d.we3 = 1'b1;
            d.rwmm = f3;
            bad = !RV64 && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
         end
         STORE: begin
            d.ra1 = rs1;
            d.ra2 = rs2;
            d.imm = imm_s;
            d.src2_selector = SRC2_IMM;
            d.wem = 1'b1;
            d.rwmm = f3;
         end
         MISC_MEM, SYSTEM: d = '0;
         default: bad = 1'b1;
      endcase
      d.illegal = bad;
      if (bad) begin
         d.we3 = 1'b0;
         d.wem = 1'b0;
         d.is_branch_op = 1'b0;
         d.is_muldiv = 1'b0;
      end
      if (!d.we3) d.wa3 = 5'd0;
   end

   assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with 2-entry skid buffer, flush and PC sideband; DECODE_MULDIV_EN enables M-extension decode
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      ra1,
   output logic [4:0]      ra2,
   output logic [4:0]      wa3,
   output logic [2:0]      funct3,
   output logic [2:0]      rwmm,
   output logic [6:0]      funct7,
   output logic            src1_selector,
   output logic            src2_selector,
   output logic            wd3_selector,
   output logic            we3,
   output logic            wem,
   output logic            is_branch_op,
   output logic            is_word_op,
   output logic            is_muldiv,
   output logic            illegal
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t          state;
   decoded_t        dec, main_q, skid_q;
   logic [PC_W-1:0] main_pc, skid_pc;
   logic            in_xfer, out_xfer, imm_unused;

   decode_comb #(.XLEN(XLEN)) u_comb (.instr(in_instr), .dec(dec));

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // occupancy FSM: main register drives the outputs, skid absorbs one extra bundle so in_ready can be registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
         main_pc <= '0;
         skid_pc <= '0;
      end else if (flush) begin
         state <= EMPTY;
         in_ready <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: if (in_xfer) begin
               main_q <= dec;
               main_pc <= in_pc;
               out_valid <= 1'b1;
               state <= ONE;
            end
            ONE: if (in_xfer && !out_xfer) begin
               skid_q <= dec;
               skid_pc <= in_pc;
               in_ready <= 1'b0;
               state <= FULL;
            end else if (in_xfer) begin
               main_q <= dec;
               main_pc <= in_pc;
            end else if (out_xfer) begin
               out_valid <= 1'b0;
               state <= EMPTY;
            end
            FULL: if (out_xfer) begin
               main_q <= skid_q;
               main_pc <= skid_pc;
               in_ready <= 1'b1;
               state <= ONE;
            end
            default: begin
               state <= EMPTY;
               in_ready <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_pc        = main_pc;
   assign imm           = main_q.imm[XLEN-1:0];
   assign ra1           = main_q.ra1;
   assign ra2           = main_q.ra2;
   assign wa3           = main_q.wa3;
   assign funct3        = main_q.funct3;
   assign rwmm          = main_q.rwmm;
   assign funct7        = main_q.funct7;
   assign src1_selector = main_q.src1_selector;
   assign src2_selector = main_q.src2_selector;
   assign wd3_selector  = main_q.wd3_selector;
   assign we3           = main_q.we3;
   assign wem           = main_q.wem;
   assign is_branch_op  = main_q.is_branch_op;
   assign is_word_op    = main_q.is_word_op;
   assign is_muldiv     = main_q.is_muldiv;
   assign illegal       = main_q.illegal;
   assign imm_unused    = ^main_q.imm;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage with valid/ready handshake on both sides.
- Sits between the fetch stage and the register-read/execute stage.
- A 2-entry skid buffer lets `in_ready` be a pure register output.
- Adds illegal-instruction detection, flush, RV64 word-op decode, and a PC sideband.

Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 or 64.
- PC_W, 32, width of the PC sideband carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage accepts when asserted; registered.
- in_instr  input  32  raw instruction.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts.
- out_pc  output  PC_W  PC of the decoded instruction.
- imm  output  XLEN  sign-extended immediate.
- ra1, ra2, wa3  output  5 each  read/write register addresses.
- funct3, rwmm  output  3 each  ALU op select and memory access mode.
- funct7  output  7  ALU op modifier.
- src1_selector  output  1  0 = reg, 1 = PC.
- src2_selector  output  1  0 = reg, 1 = imm.
- wd3_selector  output  1  0 = ALU, 1 = memory.
- we3, wem  output  1 each  register-file and memory write enables.
- is_branch_op  output  1  JAL, JALR or BRANCH.
- is_word_op  output  1  OP-32/OP-IMM-32; always 0 when XLEN = 32.
- is_muldiv  output  1  M-extension op.
- illegal  output  1  instruction not decodable.

Behaviour:
- Reset: all outputs 0, except in_ready = 1; both buffer entries invalid.
- Latency: an instruction accepted at edge N appears on outputs after edge N (out_valid high in cycle N+1), provided no older entry is pending.
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Output stability: while out_valid & ~out_ready, every output is held stable.
- States (occupancy):
  - EMPTY: in_ready = 1, out_valid = 0.
  - ONE: main register valid, in_ready = 1.
  - FULL: main and skid both valid, in_ready = 0.
- Transitions:
  - EMPTY → ONE on input transfer.
  - ONE → FULL on input transfer without output transfer; the new bundle goes to the skid register.
  - ONE → EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfer.
  - FULL → ONE on output transfer; the skid register moves to the main register.
- in_ready is computed from next state (registered): in_ready = (next_state != FULL).
- Ordering is strictly FIFO.
- Decode happens combinationally on in_instr before registering; the decoded bundle is stored, not the raw instruction.
- Immediates, sign-extended to XLEN from instr[31]:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}, sign-extended.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Per-opcode fields:
  - OP_IMM, LOAD, JALR: ra1 = rs1, ra2 = 0.
  - OP, STORE, BRANCH: ra1 = rs1, ra2 = rs2.
  - BRANCH: src1 = PC, src2 = imm, we3 = 0, funct3 = instr funct3.
  - LOAD/STORE: rwmm = funct3.
  - LOAD: wd3_selector = 1.
  - STORE: wem = 1, we3 = 0.
- wa3 is forced to 0 whenever we3 = 0.
- Illegal when any of:
  - instr[1:0] != 2'b11;
  - opcode is not in the supported set;
  - XLEN = 32 and the opcode is OP-32/OP-IMM-32;
  - shift with shamt[5] set when XLEN = 32;
  - OP funct7 not in {0000000, 0100000, and 0000001 if enabled};
  - LOAD funct3 = 3'b011/3'b110/3'b111 when XLEN = 32.
- When illegal: we3 = wem = is_branch_op = 0; the instruction still flows through with illegal = 1.
- Flush:
  - Next state = EMPTY, in_ready = 1.
  - A simultaneous input transfer is dropped.
  - Flush has priority over everything except rst_n.
- Reset asserted mid-transfer: state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: DECODE_MULDIV_EN.
- Defined:
  - OP/OP-32 with funct7 = 0000001 is legal.
  - is_muldiv = 1; funct3 selects MUL..REMU.
- Undefined:
  - that encoding is illegal.
  - is_muldiv is tied to 0.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM, OP_IMM_32, OP_32);
  - selector encodings;
  - packed struct decoded_t holding all bundle fields.
- Sub-module decode_comb: purely combinational, XLEN-parametrised, maps instr → decoded_t.
- decode_stage owns the skid buffer, handshake and flush.

Test Plan:
- Stream ADDI x1,x0,5 (0x00500093), then LUI x2,0x12345, with out_ready = 1 → one-cycle latency each; imm = 5 then 0x12345000; we3 = 1; illegal = 0.
- Hold out_ready = 0 and push 3 instructions → first two accepted; in_ready drops after the 2nd; the 3rd is accepted only after out_ready rises; output order preserved.
- BEQ with offset −8 → imm = all-ones…FFF8; src1_selector = 1; is_branch_op = 1; we3 = 0; wa3 = 0.
- XLEN = 32 with ADDIW (opcode 0011011), instr = 0x00000000, and SLLI shamt = 32 → illegal = 1, we3 = 0. Repeat with XLEN = 64: ADDIW legal with is_word_op = 1.
- FULL state, then flush together with in_valid → next cycle out_valid = 0, in_ready = 1; the flushed and the concurrent instruction never appear.
- MUL x3,x1,x2 (0x022081B3) → is_muldiv = 1, legal with DECODE_MULDIV_EN; illegal = 1 without it.
